dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory slave sitting on the far end of the CPU data port (dmem_addr, dmem_wen, dmem_data). It responds to that port.
- Holds a word-addressed RAM and returns synchronous read data on the shared bidirectional bus.
- Accepts writes driven by the CPU, with bus-turnaround control.
- After reset, a clear FSM zeroes the array before the memory reports ready.
- Sticky error flags and a saturating write counter are provided for debug and test.

Parameters:
DEPTH, 1024, number of 32-bit words (power of 2, >=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
dmem_wen  input  1  CPU write enable; 1=CPU drives dmem_data, 0=read cycle
dmem_addr  input  32  CPU byte address
dmem_data  inout  32  shared data bus; driven by responder only per drive rule below
mem_ready  output  1  1 once clear sequence completes
misalign_err  output  1  sticky: access with addr[1:0]!=0 seen while ready
range_err  output  1  sticky: access with word index >= DEPTH seen while ready
wr_count  output  32  number of accepted writes, saturating

Behaviour:
- Reset behaviour:
  - Async assert of rst sets FSM=CLEAR, clr_idx=0 and mem_ready=0.
  - misalign_err, range_err and wr_count are cleared to 0.
  - The read register is cleared to 0, drive_q=0, and dmem_data goes high-Z immediately.
  - Array contents are not reset directly; the clear FSM zeroes them.
- FSM states:
  - CLEAR: each clock writes 0 to mem[clr_idx] and increments clr_idx. When clr_idx==DEPTH-1 the last word is written and the next state is READY.
  - READY: normal operation; mem_ready=1. READY is terminal until rst.
  - Clear takes exactly DEPTH cycles; mem_ready is first seen high after the DEPTH-th rising edge following rst deassertion.
- Address decode:
  - off = dmem_addr - BASE_ADDR (32-bit wrap).
  - widx = off[31:2].
  - aligned = (off[1:0]==0).
  - in_range = (widx < DEPTH).
  - valid = READY & aligned & in_range.
- Write:
  - At a rising edge with dmem_wen=1 & valid: mem[widx] <= dmem_data, and wr_count increments, holding at 32'hFFFF_FFFF.
- Read:
  - At a rising edge with dmem_wen=0 & READY: rdata_q <= valid ? mem[widx] : 0, and drive_q <= 1.
  - At any other edge drive_q <= 0.
  - Read latency is 1 cycle: address presented in cycle N, data on the bus during cycle N+1.
- Drive rule (combinational): dmem_data = (drive_q & ~dmem_wen) ? rdata_q : 'z.
  - The responder releases the bus in the same cycle the CPU raises dmem_wen, so there is no contention.
- Read-after-write:
  - A write committed at edge k is visible to a read sampled at edge k+1; no bypass is needed.
  - A read sampled at the same edge as a write cannot occur, since dmem_wen selects exactly one.
- Errors:
  - In READY, any cycle (read or write) with !aligned sets misalign_err; with !in_range it sets range_err. Both can set together.
  - Invalid writes are dropped; invalid reads return 0.
  - Accesses during CLEAR are ignored, flag nothing, and the bus stays high-Z.
- Reset mid-operation (CLEAR or READY) restarts the full clear; prior contents are lost.
- Undefined (X/Z) dmem_data during a write is stored as-is; this is not checked.

Test Plan:
1. DEPTH=16, rst pulse then deasserted -> mem_ready=0 and dmem_data=Z for 16 edges; mem_ready=1 after the 16th edge; read of 0x3C returns 0x00000000.
2. Write 0xDEADBEEF to 0x8 (wen=1), next cycle read 0x8 (wen=0) -> dmem_data=0xDEADBEEF in the following cycle; wr_count=1; both error flags 0.
3. Write 0x12345678 to 0x6 -> no store, misalign_err=1 and stays 1; read 0x4 returns 0x00000000; wr_count unchanged.
4. DEPTH=16, read 0x40 and write 0x44 -> read data 0x00000000, range_err=1, wr_count unchanged, no array word modified.
5. Read 0x8, then wen=1 in the immediately following cycle while CPU drives 0xA5A5A5A5 -> responder outputs Z in that cycle (no X on bus); mem[2]=0xA5A5A5A5 afterwards.
6. Assert rst mid-CLEAR and again after writing 0x8 in READY -> outputs zero and bus Z immediately; clear restarts for 16 cycles; read of 0x8 then returns 0x00000000, flags 0, wr_count 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-port address/control and responder status signals
interface dmem_responder_if;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic        mem_ready;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] wr_count;

  modport master (
    output dmem_wen,
    output dmem_addr,
    input  mem_ready,
    input  misalign_err,
    input  range_err,
    input  wr_count
  );

  modport slave (
    input  dmem_wen,
    input  dmem_addr,
    output mem_ready,
    output misalign_err,
    output range_err,
    output wr_count
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM responding on a shared tristate bus
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus,
  inout  wire  [31:0]        dmem_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_clr_idx;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rdata;
  logic          r_drive;
  logic          r_misalign;
  logic          r_range;
  logic [31:0]   r_wr_count;

  logic [31:0]   w_off;
  logic [29:0]   w_widx;
  logic          w_aligned;
  logic          w_in_range;
  logic          w_ready;
  logic          w_valid;
  logic          w_wr_en;
  logic          w_clr_we;
  logic [31:0]   w_wdata;

  assign w_off      = bus.dmem_addr - BASE_ADDR;
  assign w_widx     = w_off[31:2];
  assign w_aligned  = (w_off[1:0] == 2'b00);
  assign w_in_range = (w_widx < DEPTH_W);
  assign w_ready    = (r_state == S_READY);
  assign w_valid    = w_ready & w_aligned & w_in_range;
  assign w_wr_en    = bus.dmem_wen & w_valid;
  assign w_wdata    = dmem_data;

  always_comb begin
    w_next_state = r_state;
    w_clr_we     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_idx == LAST_IDX) begin
          w_next_state = S_READY;
        end
      end
      S_READY: w_next_state = S_READY;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_idx  <= '0;
      r_rdata    <= '0;
      r_drive    <= 1'b0;
      r_misalign <= 1'b0;
      r_range    <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_clr_we) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
      if (w_ready && !w_aligned) begin
        r_misalign <= 1'b1;
      end
      if (w_ready && !w_in_range) begin
        r_range <= 1'b1;
      end
      if (w_wr_en && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
      // Data is registered on every READY read cycle and driven in the next one.
      if (w_ready && !bus.dmem_wen) begin
        r_rdata <= w_valid ? r_mem[w_widx[AW-1:0]] : '0;
        r_drive <= 1'b1;
      end else begin
        r_drive <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_en) begin
        r_mem[w_widx[AW-1:0]] <= w_wdata;
      end
    end
  end

  // Release as soon as the CPU raises wen so the turnaround cycle never contends.
  assign dmem_data = (r_drive && !bus.dmem_wen) ? r_rdata : 32'bz;

  assign bus.mem_ready    = w_ready;
  assign bus.misalign_err = r_misalign;
  assign bus.range_err    = r_range;
  assign bus.wr_count     = r_wr_count;

endmodule
